// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard : in-flight register-write tracker for the ID stage.
//   Raises stall on read-after-write hazards and counts stall cycles.
//   Optional forwarding selects are enabled by defining FORWARDING_EN.
// Revision: 1.0
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_ADDR_W    = 3,
  parameter int PIPE_DEPTH    = 4,
  parameter int FWD_MIN_STAGE = 1,
  parameter int LD_FWD_STAGE  = 2,
  parameter int CNT_W         = 16,
  localparam int FS_W         = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_reg_write,
  input  logic                  issue_is_load,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  src_a_valid,
  input  logic [REG_ADDR_W-1:0] src_a_addr,
  input  logic                  src_b_valid,
  input  logic [REG_ADDR_W-1:0] src_b_addr,
  input  logic                  flush,
  input  logic                  cnt_clear,
  output logic                  stall,
  output logic [FS_W-1:0]       fwd_sel_a,
  output logic [FS_W-1:0]       fwd_sel_b,
  output logic [FS_W-1:0]       inflight_count,
  output logic [CNT_W-1:0]      stall_cycles
);

`ifdef FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PIPE_DEPTH-1:0] valid_q, valid_d;
  logic [PIPE_DEPTH-1:0] ld_q, ld_d;
  logic [REG_ADDR_W-1:0] rd_q [PIPE_DEPTH];
  logic [REG_ADDR_W-1:0] rd_d [PIPE_DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  push;
  logic [1:0]            src_vld;
  logic [REG_ADDR_W-1:0] src_addr [2];
  logic [1:0]            hit;
  logic [1:0]            hit_ld;
  logic [1:0]            unres;
  int                    hit_stage [2];
  logic [FS_W-1:0]       fsel [2];

  // Scan oldest to youngest so the youngest matching stage is the one kept.
  always_comb begin
    src_vld     = {src_b_valid, src_a_valid};
    src_addr[0] = src_a_addr;
    src_addr[1] = src_b_addr;
    hit         = '0;
    hit_ld      = '0;
    unres       = '0;
    for (int x = 0; x < 2; x++) begin
      hit_stage[x] = 0;
      fsel[x]      = '0;
      for (int s = PIPE_DEPTH - 1; s >= 0; s--) begin
        if (src_vld[x] && valid_q[s] && (rd_q[s] == src_addr[x])) begin
          hit[x]       = 1'b1;
          hit_ld[x]    = ld_q[s];
          hit_stage[x] = s;
        end
      end
      if (hit[x]) begin
        if (FWD_EN && (hit_ld[x] ? (hit_stage[x] >= LD_FWD_STAGE)
                                 : (hit_stage[x] >= FWD_MIN_STAGE)))
          fsel[x] = FS_W'(hit_stage[x] + 1);
        else
          unres[x] = 1'b1;
      end
    end
  end

  always_comb begin
    stall     = issue_valid & ~flush & (|unres);
    push      = issue_valid & issue_reg_write & ~stall & ~flush;
    fwd_sel_a = fsel[0];
    fwd_sel_b = fsel[1];
  end

  // A flush kills the stage-0 write instead of letting it age into stage 1.
  always_comb begin
    valid_d[0] = push;
    rd_d[0]    = issue_rd;
    ld_d[0]    = issue_is_load;
    for (int s = 1; s < PIPE_DEPTH; s++) begin
      valid_d[s] = valid_q[s-1] & ~(flush && (s == 1));
      rd_d[s]    = rd_q[s-1];
      ld_d[s]    = ld_q[s-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear)
      cnt_d = '0;
    else if (stall && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    ld_q <= ld_d;
    for (int s = 0; s < PIPE_DEPTH; s++)
      rd_q[s] <= rd_d[s];
  end

  always_comb begin
    inflight_count = FS_W'($countones(valid_q));
    stall_cycles   = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_hazard_scoreboard : directed vector bench for hazard_scoreboard.
// Revision: 1.0
// ============================================================================
module tb_hazard_scoreboard;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0, issue_reg_write = 1'b0, issue_is_load = 1'b0;
  logic [2:0] issue_rd = '0;
  logic       src_a_valid = 1'b0, src_b_valid = 1'b0;
  logic [2:0] src_a_addr = '0, src_b_addr = '0;
  logic       flush = 1'b0, cnt_clear = 1'b0;
  logic       stall;
  logic [2:0] fwd_sel_a, fwd_sel_b, inflight_count;
  logic [3:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  hazard_scoreboard #(
    .REG_ADDR_W(3), .PIPE_DEPTH(4), .FWD_MIN_STAGE(1), .LD_FWD_STAGE(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_reg_write(issue_reg_write),
    .issue_is_load(issue_is_load), .issue_rd(issue_rd),
    .src_a_valid(src_a_valid), .src_a_addr(src_a_addr),
    .src_b_valid(src_b_valid), .src_b_addr(src_b_addr),
    .flush(flush), .cnt_clear(cnt_clear),
    .stall(stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .inflight_count(inflight_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, iv, rw, ld;
    int   rd;
    logic av;
    int   aa;
    logic bv;
    int   ba;
    logic fl, chk;
    logic st_nf, st_f;
    int   fa_f, fb_f, inf, cnt_nf, cnt_f;
  } vec_t;

  function automatic vec_t mk(input logic r, iv, rw, ld, input int rd, input logic av,
                              input int aa, input logic bv, input int ba, input logic fl,
                              input logic chk, input logic st_nf, st_f,
                              input int fa_f, fb_f, inf, cnt_nf, cnt_f);
    vec_t v;
    v.rst = r; v.iv = iv; v.rw = rw; v.ld = ld; v.rd = rd; v.av = av; v.aa = aa;
    v.bv = bv; v.ba = ba; v.fl = fl; v.chk = chk; v.st_nf = st_nf; v.st_f = st_f;
    v.fa_f = fa_f; v.fb_f = fb_f; v.inf = inf; v.cnt_nf = cnt_nf; v.cnt_f = cnt_f;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, iv, rw, ld, input int rd, input logic av, input int aa,
                       input logic bv, input int ba, input logic fl, input logic clr);
    @(negedge clk);
    rst = r; issue_valid = iv; issue_reg_write = rw; issue_is_load = ld;
    issue_rd = 3'(rd); src_a_valid = av; src_a_addr = 3'(aa);
    src_b_valid = bv; src_b_addr = 3'(ba); flush = fl; cnt_clear = clr;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t tbl [24];

  initial begin
    // rst, iv, rw, ld, rd, av, aa, bv, ba, fl, chk | st_nf, st_f, fa_f, fb_f, inf, cnt_nf, cnt_f
    tbl[0]  = mk(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                 $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom), 0,
                 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                 $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom), 1,
                 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 1,  1, 1, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 1,  1, 0, 2, 0, 1, 1, 1);
    tbl[5]  = mk(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 1,  1, 0, 3, 0, 1, 2, 1);
    tbl[6]  = mk(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 1,  1, 0, 4, 0, 1, 3, 1);
    tbl[7]  = mk(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4, 1);
    tbl[9]  = mk(0, 1, 1, 0, 2, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4, 1);
    tbl[10] = mk(0, 1, 1, 0, 6, 1, 2, 0, 0, 1, 1,  0, 0, 0, 0, 1, 4, 1);
    tbl[11] = mk(0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4, 1);
    tbl[12] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 4, 1);
    tbl[13] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 4, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2, 4, 1);
    tbl[15] = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1,  1, 0, 2, 0, 2, 4, 1);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1,  1, 0, 0, 3, 2, 5, 1);
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1,  1, 0, 0, 4, 1, 6, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 7, 1);
    tbl[19] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 7, 1);
    tbl[20] = mk(0, 1, 1, 0, 0, 1, 0, 1, 5, 0, 1,  1, 1, 0, 0, 1, 7, 1);
    tbl[21] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 8, 2);
    tbl[22] = mk(0, 1, 1, 0, 4, 1, 4, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].rw, tbl[i].ld, tbl[i].rd, tbl[i].av, tbl[i].aa,
            tbl[i].bv, tbl[i].ba, tbl[i].fl, 0);
      if (tbl[i].chk) begin
        check($sformatf("v%0d stall", i), int'(stall), int'(FWD ? tbl[i].st_f : tbl[i].st_nf));
        check($sformatf("v%0d fwd_sel_a", i), int'(fwd_sel_a), FWD ? tbl[i].fa_f : 0);
        check($sformatf("v%0d fwd_sel_b", i), int'(fwd_sel_b), FWD ? tbl[i].fb_f : 0);
        check($sformatf("v%0d inflight", i), int'(inflight_count), tbl[i].inf);
        check($sformatf("v%0d stall_cycles", i), int'(stall_cycles),
              FWD ? tbl[i].cnt_f : tbl[i].cnt_nf);
      end
    end

    idle(5);
    check("drain inflight", int'(inflight_count), 0);

    // ALU write r5, read two cycles later
    drive(0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    check("alu t+2 stall", int'(stall), FWD ? 0 : 1);
    check("alu t+2 fwd_sel_a", int'(fwd_sel_a), FWD ? 2 : 0);
    idle(5);

    // Load r5, read on the very next cycle
    drive(0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    check("load s0 stall", int'(stall), 1);
    check("load s0 fwd_sel_a", int'(fwd_sel_a), 0);
    drive(0, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    check("load s1 stall", int'(stall), 1);
    drive(0, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    check("load s2 stall", int'(stall), FWD ? 0 : 1);
    check("load s2 fwd_sel_a", int'(fwd_sel_a), FWD ? 3 : 0);
    idle(5);

    // Saturation: repeatedly self-dependent writes of r3
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("clear before sat", int'(stall_cycles), 0);
    for (int i = 0; i < 45; i++) drive(0, 1, 1, 0, 3, 1, 3, 0, 0, 0, 0);
    check("saturated", int'(stall_cycles), 15);
    drive(0, 1, 1, 0, 3, 1, 3, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("cleared", int'(stall_cycles), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
